p2d_converter: RTL and testbench
================================

Name: p2d_converter

Overview:
- Probability-to-digital converter: the receive end of the stochastic bitstream produced by the team's LFSR-based D2P generator.
- Counts 1s in a stochastic bitstream over a window of 2^N valid samples and presents the count as a binary value through a valid/ready handshake.
- Sits at the output of stochastic compute chains (multipliers/adders on bitstreams) to return results to the binary domain.

Parameters:
- N, 8, log2 of window length; window = 2^N valid samples; N >= 1.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  one-cycle pulse; begins a conversion window (honoured only as stated below).
- bit_in  input  1  stochastic bitstream sample.
- bit_valid  input  1  bit_in is a valid sample this cycle.
- value_out  output  N+1  count of 1s in the last completed window (0..2^N).
- value_valid  output  1  value_out holds an unconsumed result.
- value_ready  input  1  consumer accepts value_out when value_valid=1.
- busy  output  1  window in progress (state ACCUM).
- overrun  output  1  sticky result-overwrite flag; tied 0 unless P2D_CONTINUOUS_EN.

Behaviour:
- Reset (async, active-high): state IDLE; value_out=0, value_valid=0, busy=0, overrun=0; sample counter (N bits) and ones counter (N+1 bits) = 0.
- States: IDLE, ACCUM, HOLD.
- IDLE: start=1 -> ACCUM next cycle, counters cleared. busy=1 exactly while in ACCUM. bit_valid ignored in IDLE.
- ACCUM: each cycle with bit_valid=1: sample_cnt+1, ones_cnt+bit_in. Cycles with bit_valid=0 change nothing. start ignored.
- Window end: the cycle the 2^N-th valid sample is accepted (sample_cnt = 2^N-1 and bit_valid=1). That sample is included in the count.
  - Next cycle: value_out = final ones count, value_valid=1, state HOLD.
  - Latency: exactly 1 cycle after the last sample.
- Width rule: ones_cnt is N+1 bits so that all-ones gives 2^N with no wrap. sample_cnt wraps naturally to 0 at window end.
- HOLD: value_out and value_valid stable while value_ready=0. The handshake completes on value_valid & value_ready at a clock edge. Next cycle: value_valid=0 and state IDLE.
  - If start=1 in the handshake cycle: go directly to ACCUM with counters cleared. No idle bubble.
  - start with value_ready=0 in HOLD is ignored.
  - bit_in/bit_valid are ignored in HOLD.
- value_out retains the last result after the handshake. Only value_valid qualifies it.
- Reset mid-window or mid-HOLD: partial count is discarded; behaviour is as after power-up reset.

Optional Feature:
- Macro: P2D_CONTINUOUS_EN.
- Defined:
  - HOLD is never entered. At window end the block returns to ACCUM with counters cleared, so the next valid sample starts the new window.
  - value_out and value_valid update exactly as above. value_ready clears value_valid at any time.
  - If a new result latches while value_valid=1 and no handshake occurs in that cycle, value_out is overwritten and overrun is set. overrun is cleared only by reset.
  - start is needed only once from IDLE. busy stays 1 after the first start.
- Undefined: behaviour as in Behaviour; overrun is constant 0.

Decomposition:
- Shared package p2d_pkg holds:
  - typedef enum p2d_state_t {IDLE, ACCUM, HOLD};
  - function for result width (N+1).
- Sub-module p2d_accumulator: sample and ones counters with clear/enable, and a window_done pulse. The top level holds the FSM, output registers and the overrun flag.

Test Plan:
- N=4, start, then 16 cycles bit_valid=1, bit_in=1 -> value_out=5'd16, value_valid=1 on the cycle after the 16th sample, busy falls the same cycle.
- N=4, 16 valid zeros -> value_out=0, value_valid=1. Handshake with value_ready=1 -> value_valid=0 next cycle, state IDLE.
- N=4, bit_valid toggling every cycle, valid samples 1,0,1,0... -> value_out=8, value_valid asserts 1 cycle after the 16th valid sample (about cycle 32). Invalid-cycle bit_in=1 must not be counted.
- N=4, result pending with value_ready=0 for 10 cycles and toggling bit_in/start -> value_out stable. Then value_ready=1 together with start -> ACCUM next cycle, new count starts from 0.
- N=4, reset asserted asynchronously mid-ACCUM after 7 ones -> all outputs 0 immediately. Then start + 16 zeros -> value_out=0, not 7.
- P2D_CONTINUOUS_EN, N=4, value_ready=0, window of 16 ones then window of 16 zeros:
  - value_out goes 16 then 0.
  - overrun=1 from the cycle the second result latches.
  - busy stays 1 throughout.
  - A repeat run without the macro shows overrun=0.

Source files
------------

// File: rtl/p2d_pkg.sv
// Shared types and helpers for the probability-to-digital converter.
// Pure declarations: no latency, no flow control.
// P2D_CONTINUOUS_EN (optional) is consumed by p2d_converter, not here.
package p2d_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } p2d_state_t;

    // A window of 2^n samples can hold 2^n ones, which needs n+1 bits.
    function automatic int result_width(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/p2d_accumulator.sv
// Sample/ones counters for one 2^N-sample window; window_done marks the last sample.
// Latency: final_count is combinational in the window_done cycle.
// Backpressure: none, en gates counting and clr has priority over en.
module p2d_accumulator
    import p2d_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        en,
    input  logic                        bit_in,
    output logic                        window_done,
    output logic [result_width(N)-1:0]  final_count
);

    localparam int W = result_width(N);

    logic [N-1:0] sample_cnt;
    logic [W-1:0] ones_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_cnt <= '0;
            ones_cnt   <= '0;
        end else if (clr) begin
            sample_cnt <= '0;
            ones_cnt   <= '0;
        end else if (en) begin
            sample_cnt <= sample_cnt + N'(1);
            ones_cnt   <= ones_cnt + W'(bit_in);
        end
    end

    // The last sample of the window is part of the count it closes.
    assign window_done = en && (sample_cnt == {N{1'b1}});
    assign final_count = ones_cnt + W'(bit_in);

endmodule

// File: rtl/p2d_converter.sv
// Counts 1s over 2^N valid bitstream samples and returns the count via valid/ready (P2D_CONTINUOUS_EN: free-running windows).
// Latency: result valid 1 cycle after the last sample of the window.
// Backpressure: HOLD waits on value_ready; in continuous mode unread results are overwritten and flagged in overrun.
module p2d_converter
    import p2d_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         bit_in,
    input  logic         bit_valid,
    output logic [N:0]   value_out,
    output logic         value_valid,
    input  logic         value_ready,
    output logic         busy,
    output logic         overrun
);

    localparam int W = result_width(N);

    p2d_state_t   state_q, state_d;
    logic         acc_clr;
    logic         acc_en;
    logic         window_done;
    logic [W-1:0] final_count;
    logic         handshake;

    assign handshake = value_valid && value_ready;

    p2d_accumulator #(.N(N)) u_acc (
        .clk         (clk),
        .reset       (reset),
        .clr         (acc_clr),
        .en          (acc_en),
        .bit_in      (bit_in),
        .window_done (window_done),
        .final_count (final_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_clr = 1'b1;
                end
            end
            ACCUM: begin
                acc_en = bit_valid;
                if (window_done) begin
`ifdef P2D_CONTINUOUS_EN
                    state_d = ACCUM;
                    acc_clr = 1'b1;
`else
                    state_d = HOLD;
`endif
                end
            end
            HOLD: begin
                if (handshake) begin
                    // Back-to-back conversions skip the idle bubble.
                    if (start) begin
                        state_d = ACCUM;
                        acc_clr = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_out   <= '0;
            value_valid <= 1'b0;
        end else if (window_done) begin
            value_out   <= final_count;
            value_valid <= 1'b1;
        end else if (handshake) begin
            value_valid <= 1'b0;
        end
    end

`ifdef P2D_CONTINUOUS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overrun <= 1'b0;
        else if (window_done && value_valid && !value_ready)
            overrun <= 1'b1;
    end
`else
    assign overrun = 1'b0;
`endif

    assign busy = (state_q == ACCUM);

endmodule

// File: tb/tb_p2d_converter.sv
// Directed bench for p2d_converter with N=4; expected counts go through a scoreboard queue.
// Build with +define+P2D_CONTINUOUS_EN to exercise the free-running variant.
module tb_p2d_converter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         bit_in;
    logic         bit_valid;
    logic [N:0]   value_out;
    logic         value_valid;
    logic         value_ready;
    logic         busy;
    logic         overrun;

    int tests = 0;
    int fails = 0;
    int exp_cnt;
    logic [31:0] sb[$];

    p2d_converter #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .value_out   (value_out),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stream input; the model counts only valid ones.
    task automatic send(input logic v, input logic b);
        bit_valid = v;
        bit_in    = b;
        if (v && b) exp_cnt++;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (value_valid !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check(tag, {31'd0, value_valid}, 32'd1);
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        check({tag, "_sb_nonempty"}, {31'd0, (sb.size() > 0)}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(tag, {27'd0, value_out}, e);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; value_ready = 1'b0;
        exp_cnt = 0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_value_out", {27'd0, value_out}, 32'd0);
        check("rst_value_valid", {31'd0, value_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);

`ifndef P2D_CONTINUOUS_EN
        // All ones: 16 of 16, result exactly one cycle after the last sample.
        pulse_start();
        check("t1_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 15; i++) send(1'b1, 1'b1);
        check("t1_not_early", {31'd0, value_valid}, 32'd0);
        send(1'b1, 1'b1);
        sb.push_back(exp_cnt);
        check("t1_latency", {31'd0, value_valid}, 32'd1);
        check("t1_busy_fall", {31'd0, busy}, 32'd0);
        pop_check("t1_all_ones");
        value_ready = 1'b1;
        tick();
        value_ready = 1'b0;

        // All zeros, then handshake back to IDLE.
        pulse_start();
        for (int i = 0; i < 16; i++) send(1'b1, 1'b0);
        sb.push_back(exp_cnt);
        wait_valid("t2_valid");
        pop_check("t2_all_zeros");
        value_ready = 1'b1;
        tick();
        value_ready = 1'b0;
        check("t2_valid_clear", {31'd0, value_valid}, 32'd0);
        check("t2_idle", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 20; i++) send(1'b1, 1'b1);
        check("t2_idle_ignores", {30'd0, busy, value_valid}, 32'd0);

        // Alternating valid with ones on invalid cycles; bit_valid during start ignored.
        bit_valid = 1'b1; bit_in = 1'b1;
        pulse_start();
        bit_valid = 1'b0; bit_in = 1'b0;
        for (int i = 0; i <= 30; i++) begin
            if (i % 2 == 0) send(1'b1, ((i / 2) % 2 == 0));
            else            send(1'b0, 1'b1);
        end
        sb.push_back(exp_cnt);
        check("t3_latency", {31'd0, value_valid}, 32'd1);
        pop_check("t3_alternating");

        // Stalled result stays put while inputs churn.
        sb.push_back(32'd8);
        for (int i = 0; i < 10; i++) begin
            start = i[0]; bit_valid = 1'b1; bit_in = ~i[0];
            tick();
        end
        start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        check("t4_hold_valid", {31'd0, value_valid}, 32'd1);
        check("t4_hold_busy", {31'd0, busy}, 32'd0);
        pop_check("t4_hold_stable");
        value_ready = 1'b1;
        pulse_start();
        value_ready = 1'b0;
        check("t4_b2b_busy", {31'd0, busy}, 32'd1);
        check("t4_b2b_valid", {31'd0, value_valid}, 32'd0);
        for (int i = 0; i < 16; i++) send(1'b1, (i < 5));
        sb.push_back(exp_cnt);
        wait_valid("t4_valid");
        pop_check("t4_fresh_count");
        value_ready = 1'b1;
        tick();
        value_ready = 1'b0;

        // Asynchronous reset mid-window discards the partial count.
        pulse_start();
        for (int i = 0; i < 7; i++) send(1'b1, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_value_out", {27'd0, value_out}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_valid", {31'd0, value_valid}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        pulse_start();
        for (int i = 0; i < 16; i++) send(1'b1, 1'b0);
        sb.push_back(exp_cnt);
        wait_valid("t5_valid");
        pop_check("t5_after_reset");

        // Without the continuous feature a second window is never started.
        for (int i = 0; i < 16; i++) send(1'b1, 1'b0);
        check("t6_no_overrun", {31'd0, overrun}, 32'd0);
        check("t6_hold_keeps", {27'd0, value_out}, 32'd0);
        check("t6_not_busy", {31'd0, busy}, 32'd0);
`else
        // Continuous: two windows back to back with the consumer stalled.
        pulse_start();
        for (int i = 0; i < 16; i++) send(1'b1, 1'b1);
        sb.push_back(exp_cnt);
        exp_cnt = 0;
        check("c1_valid", {31'd0, value_valid}, 32'd1);
        check("c1_busy", {31'd0, busy}, 32'd1);
        check("c1_no_overrun", {31'd0, overrun}, 32'd0);
        pop_check("c1_ones");
        for (int i = 0; i < 15; i++) send(1'b1, 1'b0);
        check("c2_busy_mid", {31'd0, busy}, 32'd1);
        check("c2_overrun_early", {31'd0, overrun}, 32'd0);
        send(1'b1, 1'b0);
        sb.push_back(exp_cnt);
        check("c2_overrun", {31'd0, overrun}, 32'd1);
        check("c2_busy", {31'd0, busy}, 32'd1);
        pop_check("c2_zeros");
        value_ready = 1'b1;
        tick();
        value_ready = 1'b0;
        check("c3_valid_clear", {31'd0, value_valid}, 32'd0);
        check("c3_overrun_sticky", {31'd0, overrun}, 32'd1);
        check("c3_busy", {31'd0, busy}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
